// File: rtl/stream_demux_pkg.sv
// Shared helpers for the 1xN stream demultiplexer: select-width and
// counter saturation computations.
package stream_demux_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_CNT_W = 8;

    // ceil(log2(n)), but never below 1 so a select port always exists
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // all-ones value for a counter of the given width
    function automatic logic [31:0] cnt_sat(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage : stream_demux_pkg

// File: rtl/demux_chan_slot.sv
// One-entry valid/ready register slice for a single demux output channel.
// A write and a drain in the same cycle reload the slot without a bubble.
module demux_chan_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         can_accept
);

    // Slot is free when empty or when its consumer takes the word this cycle
    assign can_accept = !valid || rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (rd_ready) begin
            valid <= 1'b0;
        end
    end

endmodule : demux_chan_slot

// File: rtl/stream_demux_1xn.sv
// Routes a valid/ready stream to one of N registered output slots; transfers
// with an out-of-range select or to a masked channel are dropped and counted.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned SEL_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [W-1:0]     in_data,
    input  logic [N-1:0]     en_mask,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [N*W-1:0]   out_data,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err,
    input  logic             clr_err
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));

    logic [N-1:0] slot_can_accept;
    logic [N-1:0] sel_hot_c;
    logic [N-1:0] wr_en_c;
    logic         legal_c;
    logic         chan_ready_c;
    logic         accept_c;
    logic         drop_c;

    // Select decode: codes without a matching channel leave legal_c low
    always_comb begin
        sel_hot_c    = '0;
        legal_c      = 1'b0;
        chan_ready_c = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hot_c[i] = 1'b1;
                legal_c      = en_mask[i];
                chan_ready_c = slot_can_accept[i];
            end
        end
    end

    // Drops are always accepted so a dead channel never blocks the producer
    assign in_ready = !legal_c || chan_ready_c;
    assign accept_c = in_valid && in_ready;
    assign drop_c   = accept_c && !legal_c;
    assign wr_en_c  = sel_hot_c & {N{accept_c && legal_c}};

    // Drop bookkeeping; a drop coinciding with clr_err restarts the count at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            err      <= 1'b0;
        end else if (drop_c) begin
            err <= 1'b1;
            if (clr_err) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != CNT_SAT) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (clr_err) begin
            drop_cnt <= '0;
            err      <= 1'b0;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_chan_slot #(
            .W (W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en_c[g]),
            .wr_data    (in_data),
            .rd_ready   (out_ready[g]),
            .valid      (out_valid[g]),
            .data       (out_data[g*W +: W]),
            .can_accept (slot_can_accept[g])
        );
    end

endmodule : stream_demux_1xn

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn: directed vector table, corner
// sequences, and randomized traffic against a per-channel queue-free model.
module tb_stream_demux_1xn;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SEL_W = 2;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [W-1:0]     in_data;
    logic [N-1:0]     en_mask;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [N*W-1:0]   out_data;
    logic [CNT_W-1:0] drop_cnt;
    logic             err;
    logic             clr_err;

    always #5 clk = ~clk;

    stream_demux_1xn #(
        .N     (N),
        .W     (W),
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .err       (err),
        .clr_err   (clr_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what each channel currently holds, plus drop stats
    bit           m_valid [N];
    logic [W-1:0] m_data  [N];
    int           m_cnt;
    bit           m_err;

    typedef struct {
        logic         v;
        logic [1:0]   sel;
        logic [7:0]   d;
        logic [3:0]   mask;
        logic [3:0]   ordy;
        logic         clr;
        logic         exp_rdy;
        logic [3:0]   exp_ov;
        logic [31:0]  exp_od;
        logic [1:0]   exp_cnt;
        logic         exp_err;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic v, input logic [1:0] sel, input logic [7:0] d,
                                 input logic [3:0] mask, input logic [3:0] ordy, input logic clr,
                                 input logic rdy, input logic [3:0] ov, input logic [31:0] od,
                                 input logic [1:0] cnt, input logic e);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.mask = mask; r.ordy = ordy; r.clr = clr;
        r.exp_rdy = rdy; r.exp_ov = ov; r.exp_od = od; r.exp_cnt = cnt; r.exp_err = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    function automatic bit m_legal();
        int s = int'(in_sel);
        return (s < N) && en_mask[s];
    endfunction

    function automatic bit m_ready();
        int s = int'(in_sel);
        if (!m_legal()) return 1'b1;
        return !m_valid[s] || out_ready[s];
    endfunction

    // Advance one clock and apply the transfer rules to the model
    task automatic tick();
        int           s     = int'(in_sel);
        bit           legal = m_legal();
        bit           acc   = in_valid && m_ready();
        logic [W-1:0] d     = in_data;
        logic [N-1:0] ordy  = out_ready;
        bit           clr   = clr_err;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc && legal && s == i) begin
                m_valid[i] = 1'b1;
                m_data[i]  = d;
            end else if (ordy[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (acc && !legal) begin
            m_cnt = clr ? 1 : ((m_cnt < SAT) ? m_cnt + 1 : m_cnt);
            m_err = 1'b1;
        end else if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0]   ev;
        logic [N*W-1:0] ed;
        for (int i = 0; i < N; i++) begin
            ev[i]         = m_valid[i];
            ed[i*W +: W]  = m_data[i];
        end
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, " out_data"},  64'(out_data),  64'(ed));
        chk({tag, " drop_cnt"},  64'(drop_cnt),  64'(m_cnt));
        chk({tag, " err"},       64'(err),       64'(m_err));
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] mask, input logic [3:0] ordy, input logic clr);
        in_valid = v; in_sel = sel; in_data = d; en_mask = mask; out_ready = ordy; clr_err = clr;
        #1;
    endtask

    initial begin
        bit hold;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b0);
        model_reset();

        tbl[0]  = mkv(1, 0, 8'hA0, 4'hF, 4'hF, 0, 1, 4'b0001, 32'h000000A0, 0, 0);
        tbl[1]  = mkv(1, 1, 8'hA1, 4'hF, 4'hF, 0, 1, 4'b0010, 32'h0000A1A0, 0, 0);
        tbl[2]  = mkv(1, 2, 8'hA2, 4'hF, 4'hF, 0, 1, 4'b0100, 32'h00A2A1A0, 0, 0);
        tbl[3]  = mkv(1, 3, 8'hA3, 4'hF, 4'hF, 0, 1, 4'b1000, 32'hA3A2A1A0, 0, 0);
        tbl[4]  = mkv(0, 0, 8'h00, 4'hF, 4'hF, 0, 1, 4'b0000, 32'hA3A2A1A0, 0, 0);
        tbl[5]  = mkv(1, 2, 8'h77, 4'hB, 4'hF, 0, 1, 4'b0000, 32'hA3A2A1A0, 1, 1);
        tbl[6]  = mkv(0, 2, 8'h77, 4'hB, 4'hF, 1, 1, 4'b0000, 32'hA3A2A1A0, 0, 0);
        tbl[7]  = mkv(1, 2, 8'h88, 4'hB, 4'hF, 1, 1, 4'b0000, 32'hA3A2A1A0, 1, 1);
        tbl[8]  = mkv(1, 2, 8'h88, 4'hB, 4'hF, 0, 1, 4'b0000, 32'hA3A2A1A0, 2, 1);
        tbl[9]  = mkv(1, 2, 8'h88, 4'hB, 4'hF, 0, 1, 4'b0000, 32'hA3A2A1A0, 3, 1);
        tbl[10] = mkv(1, 2, 8'h88, 4'hB, 4'hF, 0, 1, 4'b0000, 32'hA3A2A1A0, 3, 1);
        tbl[11] = mkv(1, 2, 8'h88, 4'hB, 4'hF, 0, 1, 4'b0000, 32'hA3A2A1A0, 3, 1);
        tbl[12] = mkv(0, 2, 8'h88, 4'hB, 4'hF, 1, 1, 4'b0000, 32'hA3A2A1A0, 0, 0);
        tbl[13] = mkv(1, 2, 8'h11, 4'hF, 4'hB, 0, 1, 4'b0100, 32'hA311A1A0, 0, 0);
        tbl[14] = mkv(1, 2, 8'h22, 4'hF, 4'hB, 0, 0, 4'b0100, 32'hA311A1A0, 0, 0);
        tbl[15] = mkv(1, 1, 8'h33, 4'hF, 4'hB, 0, 1, 4'b0110, 32'hA31133A0, 0, 0);
        tbl[16] = mkv(1, 2, 8'h22, 4'hF, 4'hF, 0, 1, 4'b0100, 32'hA32233A0, 0, 0);
        tbl[17] = mkv(0, 0, 8'h00, 4'hF, 4'hF, 0, 1, 4'b0000, 32'hA32233A0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data",  64'(out_data),  64'd0);
        chk("reset drop_cnt",  64'(drop_cnt),  64'd0);
        chk("reset err",       64'(err),       64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].mask, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
            tick();
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("v%0d out_data", i),  64'(out_data),  64'(tbl[i].exp_od));
            chk($sformatf("v%0d drop_cnt", i),  64'(drop_cnt),  64'(tbl[i].exp_cnt));
            chk($sformatf("v%0d err", i),       64'(err),       64'(tbl[i].exp_err));
        end

        // Drain and reload channel 3 in the same cycle
        drive(1, 2'd3, 8'h44, 4'hF, 4'b0111, 0);
        tick();
        chk("c3 first valid", 64'(out_valid[3]), 64'd1);
        drive(1, 2'd3, 8'h55, 4'hF, 4'hF, 0);
        chk("c3 reload in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("c3 reload valid", 64'(out_valid[3]), 64'd1);
        chk("c3 reload data",  64'(out_data[31:24]), 64'h55);
        drive(0, 2'd0, 8'h00, 4'hF, 4'hF, 0);
        tick();
        chk("c3 drained", 64'(out_valid[3]), 64'd0);

        // Fill every slot, then reset asynchronously mid-stream
        for (int i = 0; i < N; i++) begin
            drive(1, 2'(i), 8'hB0 + 8'(i), 4'hF, 4'h0, 0);
            tick();
        end
        chk("full out_valid", 64'(out_valid), 64'hF);
        chk("full out_data",  64'(out_data),  64'hB3B2B1B0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst out_data",  64'(out_data),  64'd0);
        model_reset();
        drive(1, 2'd1, 8'h99, 4'hF, 4'hF, 0);
        @(posedge clk);
        #1;
        chk("in rst no accept", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        drive(1, 2'd1, 8'h5A, 4'hF, 4'hF, 0);
        tick();
        chk("post rst valid", 64'(out_valid), 64'b0010);
        chk("post rst data",  64'(out_data[15:8]), 64'h5A);
        drive(0, 2'd0, 8'h00, 4'hF, 4'hF, 0);
        tick();
        chk_model("post rst idle");

        // Randomized traffic; the producer holds a stalled transfer
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            en_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            out_ready = 4'($urandom);
            clr_err   = 1'($urandom_range(0, 15) == 0);
            #1;
            chk($sformatf("rnd%0d in_ready", c), 64'(in_ready), 64'(m_ready()));
            hold = in_valid && !m_ready();
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_stream_demux_1xn

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
Parametrised successor to the 1x4 combinational demux. It routes a W-bit valid/ready stream to one of N output channels, selected per transfer. Each output has its own 1-entry register slice, so a stalled output does not corrupt other channels. Transfers with an illegal select or to a masked channel are dropped and counted. The block sits between a single producer and N independent consumers in the datapath.

Parameters:
N, 4, number of output channels (2..16)
W, 8, data width in bits
SEL_W, $clog2(N) (minimum 1), select width
CNT_W, 8, drop-counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  input transfer valid
in_ready  out  1  input may be accepted this cycle
in_sel  in  SEL_W  target channel, qualified by in_valid
in_data  in  W  payload
en_mask  in  N  per-channel enable; 0 means drop transfers to that channel
out_valid  out  N  per-channel valid
out_ready  in  N  per-channel ready
out_data  out  N*W  channel i occupies bits [i*W +: W]
drop_cnt  out  CNT_W  saturating count of dropped transfers
err  out  1  sticky drop flag
clr_err  in  1  synchronous clear of err and drop_cnt

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, drop_cnt=0, err=0. No transfer is accepted while rst_n=0.
- Legal transfer: in_sel < N and en_mask[in_sel]=1.
- in_ready (combinational from in_sel, en_mask, out_valid, out_ready):
  - illegal or masked transfer: 1
  - legal transfer: !out_valid[in_sel] || out_ready[in_sel]
- Accept: in_valid && in_ready.
  - Legal: out_data[in_sel] <= in_data and out_valid[in_sel] <= 1 on the next edge. Latency is 1 cycle.
  - Illegal or masked: data discarded; drop_cnt increments, saturating at 2^CNT_W-1; err <= 1.
- Channel drain: out_valid[i] && out_ready[i] with no write to channel i that cycle -> out_valid[i] <= 0. out_data[i] holds its last value.
- Drain and write to the same channel in the same cycle: new data is loaded and out_valid[i] stays 1. Throughput is 1 transfer/cycle per channel.
- While out_valid[i]=1 and out_ready[i]=0, out_data[i] is stable.
- Other channels drain independently of the input and of each other.
- Producer obligation: in_sel and in_data stay stable while in_valid=1 and in_ready=0. The block does not check this.
- en_mask changes affect only new accepts. Data already held in a slot is still delivered.
- clr_err: drop_cnt <= 0 and err <= 0.
  - Same cycle as a drop: set wins, giving err=1 and drop_cnt=1.
- Reset mid-operation: all held data is lost and out_valid clears immediately (asynchronous). Deassertion is synchronised externally.
- N not a power of 2: select codes N..2^SEL_W-1 are illegal and are dropped.
- No combinational path from in_valid to out_valid.

Decomposition:
- Package stream_demux_pkg:
  - function for the minimum-1 clog2 used by SEL_W
  - localparam for the counter saturation value
- Sub-module demux_chan_slot, instantiated N times in a generate loop.
  - Contains the 1-entry W-bit register with valid/ready.
  - Ports: clk, rst_n, wr_en, wr_data, rd_ready, valid, data, can_accept.
- The top level holds select decode, legality check, in_ready mux and drop counter.

Test Plan:
- Reset, then N=4, W=8: send 0xA0..0xA3 to sel 0..3 with all out_ready=1 -> each out_valid[i] pulses 1 cycle after accept, with out_data[i]=0xA0+i; drop_cnt=0.
- Hold out_ready[2]=0; send 0x11 to sel 2, then 0x22 to sel 2 -> second transfer stalls (in_ready=0), out_data[2] stays 0x11. Meanwhile 0x33 to sel 1 is accepted.
- out_valid[3]=1 with out_ready[3]=1; write 0x55 to sel 3 in the same cycle -> out_valid[3] stays 1 and out_data[3]=0x55 next cycle.
- en_mask=4'b1011; send to sel 2 -> in_ready=1, nothing delivered, drop_cnt=1, err=1. Then pulse clr_err -> both 0.
- CNT_W=2: 5 drops -> drop_cnt saturates at 3. clr_err coinciding with a drop -> drop_cnt=1, err=1.
- Assert rst_n=0 mid-stream with slots full -> out_valid=0 immediately. After release, the first transfer is delivered correctly.
